// File: rtl/trap_event_ctrl_pkg.sv
// trap_event_ctrl_pkg
// Shared types and default timing constants for the trapezoidal-filter
// sequencing controller. The defaults are derived from the filter shape
// (rise time k_v_5, flat top l_v_5) and the filter pipeline depth.
package trap_event_ctrl_pkg;

    localparam int SIZE_FILTER_DATA = 16;

    localparam int K_V_5           = 12;
    localparam int L_V_5           = 4;
    localparam int FILT_PIPE_DEPTH = 16;

    // Filter output is meaningless until the k+l window and the pipeline have filled.
    localparam int DEF_SETTLE_CYC = K_V_5 + L_V_5 + FILT_PIPE_DEPTH;
    // The flat top starts roughly k-l samples after the leading edge crosses threshold.
    localparam int DEF_PEAK_DLY   = K_V_5 - L_V_5;
    // Anything wider than a few full trapezoids is treated as overlapping pulses.
    localparam int DEF_MAX_WIDTH  = 4 * (K_V_5 + L_V_5);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_FLAT      = 3'd3,
        S_WAIT_FALL = 3'd4
    } trap_ctrl_state_t;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic                               pileup;
    } trap_result_t;

endpackage

// File: rtl/trap_event_ctrl_if.sv
// trap_event_ctrl_if
// Result handshake between the controller and the readout/histogram logic.
//   res_data   : captured flat-top amplitude (signed)
//   res_pileup : pile-up flag belonging to res_data
//   res_valid  : result available
//   res_ready  : consumer accepts when res_valid and res_ready are both 1
// master = controller side, slave = consumer side.
interface trap_event_ctrl_if
    import trap_event_ctrl_pkg::*;
#(
    parameter int DATA_W = SIZE_FILTER_DATA
);

    logic signed [DATA_W-1:0] res_data;
    logic                     res_pileup;
    logic                     res_valid;
    logic                     res_ready;

    modport master (
        output res_data,
        output res_pileup,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_pileup,
        input  res_valid,
        output res_ready
    );

endinterface

// File: rtl/trap_event_ctrl_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones.
//   clk   : clock, rising edge
//   reset : synchronous, active-low clear
//   clr   : synchronous clear
//   inc   : count one event
//   count : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/trap_event_ctrl.sv
// trap_event_ctrl
// Sequencing controller for the trapezoidal shaping filter. Holds the filter
// cleared while idle, waits out the pipeline fill after start, triggers on the
// filtered stream, captures the flat-top amplitude PEAK_DLY samples after the
// trigger, flags pile-up on over-wide pulses and offers one result per pulse.
//   clk        : clock, rising edge
//   reset      : synchronous, active-low
//   enable     : 1 = acquire, 0 = stop and keep filter cleared
//   threshold  : signed trigger level, sampled only while idle
//   filt_data  : signed filter output, one sample per clock
//   filt_run   : filter run (1) / clear (0)
//   busy       : 1 in any state other than idle
//   evt_count  : results loaded into the slot, saturating
//   drop_count : results lost to a full slot, saturating
//   res        : result handshake (master side)
module trap_event_ctrl
    import trap_event_ctrl_pkg::*;
#(
    parameter int DATA_W     = SIZE_FILTER_DATA,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int PEAK_DLY   = DEF_PEAK_DLY,
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic signed [DATA_W-1:0] filt_data,
    output logic                     filt_run,
    output logic                     busy,
    output logic [15:0]              evt_count,
    output logic [7:0]               drop_count,
    trap_event_ctrl_if.master        res
);

    localparam logic [2:0] IDLE      = 3'(S_IDLE);
    localparam logic [2:0] SETTLE    = 3'(S_SETTLE);
    localparam logic [2:0] WAIT_TRIG = 3'(S_WAIT_TRIG);
    localparam logic [2:0] FLAT      = 3'(S_FLAT);
    localparam logic [2:0] WAIT_FALL = 3'(S_WAIT_FALL);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int WW = $clog2(MAX_WIDTH + 2);

    logic [2:0]               state;
    logic [2:0]               state_nxt;
    logic [SW-1:0]            settle_cnt;
    logic [WW-1:0]            width_cnt;
    logic [7:0]               dly_cnt;
    logic signed [DATA_W-1:0] thr_q;
    logic signed [DATA_W-1:0] peak_q;

    logic above;
    logic capture;
    logic fall_issue;
    logic slot_free;
    logic evt_inc;
    logic drop_inc;

    always_comb begin
        above   = filt_data > thr_q;
        capture = (state == FLAT) && above && (dly_cnt == 8'(PEAK_DLY));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (enable) state_nxt = SETTLE;
            SETTLE:    if (settle_cnt == SW'(1)) state_nxt = WAIT_TRIG;
            WAIT_TRIG: if (above) state_nxt = FLAT;
            FLAT: begin
                // A drop below threshold before the capture point is a runt.
                if (!above)       state_nxt = WAIT_TRIG;
                else if (capture) state_nxt = WAIT_FALL;
            end
            WAIT_FALL: if (!above) state_nxt = WAIT_TRIG;
            default:   state_nxt = IDLE;
        endcase
        // Disabling abandons whatever pulse is in flight.
        if (!enable) state_nxt = IDLE;
    end

    always_comb begin
        fall_issue = enable && (state == WAIT_FALL) && !above;
        // An accept in the issue cycle frees the slot for the new result.
        slot_free  = !res.res_valid || res.res_ready;
        evt_inc    = fall_issue && slot_free;
        drop_inc   = fall_issue && !slot_free;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            filt_run   <= 1'b0;
            busy       <= 1'b0;
            settle_cnt <= '0;
            width_cnt  <= '0;
            dly_cnt    <= '0;
            thr_q      <= '0;
            peak_q     <= '0;
        end else begin
            state    <= state_nxt;
            filt_run <= (state_nxt != IDLE);
            busy     <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    thr_q      <= threshold;
                    settle_cnt <= SW'(SETTLE_CYC);
                end
                SETTLE: settle_cnt <= settle_cnt - SW'(1);
                WAIT_TRIG: begin
                    // Loaded every cycle; only meaningful once the trigger fires.
                    width_cnt <= WW'(1);
                    dly_cnt   <= 8'd1;
                end
                FLAT: begin
                    width_cnt <= width_cnt + WW'(1);
                    dly_cnt   <= dly_cnt + 8'd1;
                    if (capture) peak_q <= filt_data;
                end
                WAIT_FALL: begin
                    if (width_cnt <= WW'(MAX_WIDTH)) width_cnt <= width_cnt + WW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result slot: width_cnt at the falling sample counts the trigger sample
    // through the last sample above threshold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res.res_data   <= '0;
            res.res_pileup <= 1'b0;
            res.res_valid  <= 1'b0;
        end else if (evt_inc) begin
            res.res_data   <= peak_q;
            res.res_pileup <= (width_cnt > WW'(MAX_WIDTH));
            res.res_valid  <= 1'b1;
        end else if (res.res_valid && res.res_ready) begin
            res.res_valid  <= 1'b0;
        end
    end

    sat_counter #(.WIDTH(16)) u_evt_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (evt_inc),
        .count (evt_count)
    );

    sat_counter #(.WIDTH(8)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (drop_inc),
        .count (drop_count)
    );

endmodule

// File: tb/tb_trap_event_ctrl.sv
// tb_trap_event_ctrl
// Self-checking bench for trap_event_ctrl. Each scenario builds a per-cycle
// filter trace and ready pattern, runs it, and compares every cycle against a
// reference that derives pulses and results directly from the trace.
module tb_trap_event_ctrl;

    localparam int THR    = 100;
    localparam int SETTLE = 32;
    localparam int PDLY   = 8;
    localparam int MAXW   = 64;
    localparam int MAXN   = 700;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [15:0] threshold;
    logic signed [15:0] filt_data;
    logic               filt_run;
    logic               busy;
    logic [15:0]        evt_count;
    logic [7:0]         drop_count;

    trap_event_ctrl_if #(.DATA_W(16)) res_if ();

    trap_event_ctrl #(
        .DATA_W     (16),
        .SETTLE_CYC (SETTLE),
        .PEAK_DLY   (PDLY),
        .MAX_WIDTH  (MAXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .threshold  (threshold),
        .filt_data  (filt_data),
        .filt_run   (filt_run),
        .busy       (busy),
        .evt_count  (evt_count),
        .drop_count (drop_count),
        .res        (res_if)
    );

    always #5 clk = ~clk;

    int          trace [MAXN];
    bit          rdy   [MAXN];
    logic [43:0] obs   [MAXN];
    logic [43:0] expv  [MAXN];
    int          n_cmp = 0;
    int          n_err = 0;

    // {filt_run, busy, valid, pileup, data[15:0], evt[15:0], drop[7:0]}
    function automatic logic [43:0] snap();
        return {filt_run, busy, res_if.res_valid, res_if.res_pileup,
                res_if.res_data, evt_count, drop_count};
    endfunction

    function automatic int below_val();
        return int'($urandom_range(0, 600)) - 500;
    endfunction

    function automatic int above_val();
        return THR + 1 + int'($urandom_range(0, 20000));
    endfunction

    task automatic fill_base(int n, bit r);
        for (int c = 0; c < n; c++) begin
            trace[c] = below_val();
            rdy[c]   = r;
        end
    endtask

    task automatic add_pulse(int s, int len);
        for (int i = 0; i < len; i++) trace[s + i] = above_val();
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        enable           = 1'b0;
        threshold        = 16'(THR);
        filt_data        = '0;
        res_if.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive_trace(int n);
        for (int c = 0; c < n; c++) begin
            enable           = 1'b1;
            filt_data        = 16'(trace[c]);
            res_if.res_ready = rdy[c];
            threshold        = (c == 0) ? 16'(THR) : 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
            obs[c] = snap();
        end
    endtask

    // Reference: scan the trace for pulses as whole segments, then play the
    // resulting issue events through a one-entry result slot.
    task automatic build_model(int n);
        bit iss [MAXN];
        int iamp [MAXN];
        bit ipile [MAXN];
        int t, len, d, evt, drop;
        bit v, p;
        for (int c = 0; c < n; c++) begin
            iss[c] = 1'b0; iamp[c] = 0; ipile[c] = 1'b0;
        end
        t = SETTLE + 1;
        while (t < n) begin
            if (trace[t] > THR) begin
                len = 0;
                while ((t + len < n) && (trace[t + len] > THR)) len++;
                if (t + len >= n) break;
                if (len > PDLY) begin
                    iss[t + len]   = 1'b1;
                    iamp[t + len]  = trace[t + PDLY];
                    ipile[t + len] = (len > MAXW);
                end
                t = t + len + 1;
            end else begin
                t++;
            end
        end
        v = 0; p = 0; d = 0; evt = 0; drop = 0;
        for (int c = 0; c < n; c++) begin
            if (iss[c]) begin
                if (!v || rdy[c]) begin
                    v = 1; d = iamp[c]; p = ipile[c];
                    if (evt < 65535) evt++;
                end else if (drop < 255) begin
                    drop++;
                end
            end else if (v && rdy[c]) begin
                v = 0;
            end
            expv[c] = {1'b1, 1'b1, v, p, 16'(d), 16'(evt), 8'(drop)};
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        enable    = 1'b1;
        filt_data = 16'sd500;
        @(posedge clk);
        #1;
        n_cmp++;
        if (snap() !== 44'd0) begin
            n_err++;
            $display("FAIL reset_state got %h exp %h", snap(), 44'd0);
        end
    endtask

    task automatic test_settle();
        int n = 80;
        do_reset();
        fill_base(n, 1'b0);
        for (int c = 0; c < 53; c++) trace[c] = 500;
        trace[41] = 777;
        drive_trace(n);
        build_model(n);
        for (int c = 0; c < n; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL settle cyc%0d got %h exp %h", c, obs[c], expv[c]);
            end
        end
        n_cmp++;
        if (obs[0][43] !== 1'b1) begin
            n_err++;
            $display("FAIL settle_run_c1 got %b exp 1", obs[0][43]);
        end
        n_cmp++;
        if (res_if.res_data !== 16'sd777) begin
            n_err++;
            $display("FAIL settle_amp got %0d exp 777", res_if.res_data);
        end
    endtask

    task automatic test_pulse();
        int n = 100;
        do_reset();
        fill_base(n, 1'b0);
        add_pulse(40, 20);
        trace[48] = 1234;
        drive_trace(n);
        build_model(n);
        for (int c = 0; c < n; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL pulse cyc%0d got %h exp %h", c, obs[c], expv[c]);
            end
        end
        n_cmp++;
        if ({res_if.res_valid, res_if.res_pileup, res_if.res_data, evt_count, drop_count}
            !== {1'b1, 1'b0, 16'sd1234, 16'd1, 8'd0}) begin
            n_err++;
            $display("FAIL pulse_result got v%b p%b d%0d e%0d dr%0d exp v1 p0 d1234 e1 dr0",
                     res_if.res_valid, res_if.res_pileup, res_if.res_data, evt_count, drop_count);
        end
    endtask

    task automatic test_runt();
        int n = 120;
        do_reset();
        fill_base(n, 1'b0);
        add_pulse(40, 8);
        add_pulse(60, 9);
        add_pulse(90, 5);
        drive_trace(n);
        build_model(n);
        for (int c = 0; c < n; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL runt cyc%0d got %h exp %h", c, obs[c], expv[c]);
            end
        end
        n_cmp++;
        if ({evt_count, res_if.res_data} !== {16'd1, 16'(trace[68])}) begin
            n_err++;
            $display("FAIL runt_count got e%0d d%0d exp e1 d%0d", evt_count, res_if.res_data, trace[68]);
        end
    endtask

    task automatic test_pileup();
        int n = 300;
        do_reset();
        fill_base(n, 1'b1);
        add_pulse(40, 70);
        add_pulse(120, 64);
        add_pulse(200, 65);
        drive_trace(n);
        build_model(n);
        for (int c = 0; c < n; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL pileup cyc%0d got %h exp %h", c, obs[c], expv[c]);
            end
        end
        n_cmp++;
        if ({obs[110][41:40], obs[184][41:40], obs[265][41:40], evt_count} !== {2'b11, 2'b10, 2'b11, 16'd3}) begin
            n_err++;
            $display("FAIL pileup_flags got %b%b%b e%0d exp 111011 e3",
                     obs[110][41:40], obs[184][41:40], obs[265][41:40], evt_count);
        end
    endtask

    task automatic test_back_to_back();
        int n = 110;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            fill_base(n, 1'b0);
            add_pulse(40, 20);
            add_pulse(70, 20);
            if (pass == 1) rdy[90] = 1'b1;
            drive_trace(n);
            build_model(n);
            for (int c = 0; c < n; c++) begin
                n_cmp++;
                if (obs[c] !== expv[c]) begin
                    n_err++;
                    $display("FAIL b2b%0d cyc%0d got %h exp %h", pass, c, obs[c], expv[c]);
                end
            end
            n_cmp++;
            if (pass == 0) begin
                if ({res_if.res_valid, res_if.res_data, evt_count, drop_count}
                    !== {1'b1, 16'(trace[48]), 16'd1, 8'd1}) begin
                    n_err++;
                    $display("FAIL b2b_drop got d%0d e%0d dr%0d exp d%0d e1 dr1",
                             res_if.res_data, evt_count, drop_count, trace[48]);
                end
            end else begin
                if ({res_if.res_valid, res_if.res_data, evt_count, drop_count}
                    !== {1'b1, 16'(trace[78]), 16'd2, 8'd0}) begin
                    n_err++;
                    $display("FAIL b2b_reload got d%0d e%0d dr%0d exp d%0d e2 dr0",
                             res_if.res_data, evt_count, drop_count, trace[78]);
                end
            end
        end
    endtask

    task automatic test_abort_reset();
        int n = 73;
        do_reset();
        fill_base(n + 4, 1'b0);
        add_pulse(40, 20);
        add_pulse(70, 30);
        drive_trace(n);
        build_model(n);
        for (int c = 0; c < n; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL abort cyc%0d got %h exp %h", c, obs[c], expv[c]);
            end
        end
        enable    = 1'b0;
        filt_data = 16'(trace[n]);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({filt_run, busy, res_if.res_valid, res_if.res_data, evt_count}
            !== {1'b0, 1'b0, 1'b1, 16'(trace[48]), 16'd1}) begin
            n_err++;
            $display("FAIL abort_idle got run%b busy%b v%b d%0d e%0d exp run0 busy0 v1 d%0d e1",
                     filt_run, busy, res_if.res_valid, res_if.res_data, evt_count, trace[48]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (res_if.res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL abort_hold got v%b exp v1", res_if.res_valid);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (snap() !== 44'd0) begin
            n_err++;
            $display("FAIL abort_reset got %h exp %h", snap(), 44'd0);
        end
        reset = 1'b1;
    endtask

    task automatic test_random();
        int n = 600;
        int t, gap, len;
        for (int it = 0; it < 5; it++) begin
            do_reset();
            t = 0;
            while (t < n) begin
                gap = int'($urandom_range(1, 10));
                len = int'($urandom_range(1, 80));
                for (int i = 0; i < gap && t < n; i++) begin trace[t] = below_val(); t++; end
                for (int i = 0; i < len && t < n; i++) begin trace[t] = above_val(); t++; end
            end
            for (int c = 0; c < n; c++) rdy[c] = ($urandom_range(0, 9) < 3);
            drive_trace(n);
            build_model(n);
            for (int c = 0; c < n; c++) begin
                n_cmp++;
                if (obs[c] !== expv[c]) begin
                    n_err++;
                    $display("FAIL rand%0d cyc%0d got %h exp %h", it, c, obs[c], expv[c]);
                end
            end
        end
    endtask

    initial begin
        reset            = 1'b0;
        enable           = 1'b0;
        threshold        = 16'(THR);
        filt_data        = '0;
        res_if.res_ready = 1'b0;
        test_reset();
        test_settle();
        test_pulse();
        test_runt();
        test_pileup();
        test_back_to_back();
        test_abort_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trap_event_ctrl.md
Name: trap_event_ctrl

Overview:
- Sequencing controller for the trapezoidal shaping filter. It gates the filter run/clear input and waits out the filter pipeline fill.
- It arms on the filtered stream, captures the flat-top amplitude of each pulse, flags pile-up, and emits one result per pulse over a valid/ready handshake.
- It sits between the filter output and the readout/histogram logic.

Parameters:
- DATA_W, 16 (SIZE_FILTER_DATA): filter sample width, signed.
- SETTLE_CYC, 32: cycles to ignore filter output after filt_run rises. Must be at least k+l plus the filter pipeline depth.
- PEAK_DLY, 8: cycles from the trigger sample to the flat-top capture sample. Range 1..255.
- MAX_WIDTH, 64: maximum cycles above threshold before a pulse is flagged as pile-up. Must be greater than PEAK_DLY.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low: 0 clears the block, 1 runs it.
- enable  in  1  1 = acquisition on; 0 = stop and hold the filter cleared.
- threshold  in  DATA_W  signed trigger level; sampled only in IDLE.
- filt_data  in  DATA_W  signed filter output sample, one per clk.
- filt_run  out  1  drives the filter reset/run pin; 1 = filter runs, 0 = filter cleared.
- res_data  out  DATA_W  captured flat-top amplitude.
- res_pileup  out  1  pile-up flag belonging to res_data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result when res_valid=1 and res_ready=1.
- busy  out  1  1 in any state except IDLE.
- evt_count  out  16  emitted results, saturating at 0xFFFF.
- drop_count  out  8  results lost because the slot was full, saturating at 0xFF.

Behaviour:
- reset=0 (synchronous): state=IDLE. filt_run, res_valid, res_pileup, busy = 0. res_data, evt_count, drop_count, all internal counters and thr_q = 0. This applies mid-operation too; a pending result is discarded.
- States: IDLE, SETTLE, WAIT_TRIG, FLAT, WAIT_FALL. All outputs are registered.
- IDLE:
  - thr_q <= threshold every cycle.
  - On enable=1, go to SETTLE; filt_run=1 from the next cycle. Settle counter is loaded with SETTLE_CYC.
- SETTLE:
  - Counter decrements each cycle; filt_data is ignored.
  - At counter==1, go to WAIT_TRIG. Exactly SETTLE_CYC cycles are spent in SETTLE.
- WAIT_TRIG:
  - If filt_data > thr_q (signed, strict), go to FLAT. Width counter=1, delay counter=1.
- FLAT:
  - Width and delay counters increment each cycle.
  - If filt_data <= thr_q before capture: runt pulse. Return to WAIT_TRIG; nothing is emitted or counted.
  - On the sample that is PEAK_DLY cycles after the trigger sample: peak_q <= filt_data, go to WAIT_FALL.
  - PEAK_DLY=1 captures the sample immediately after the trigger.
- WAIT_FALL:
  - Width counter increments, saturating at MAX_WIDTH+1.
  - On the first sample with filt_data <= thr_q, issue the result and return to WAIT_TRIG the next cycle.
  - pileup = (width counter > MAX_WIDTH), where the count includes the trigger sample and excludes the falling sample.
  - No timeout exit: the block stays in WAIT_FALL until the pulse falls.
- Result issue, effective the cycle after the falling sample:
  - Slot is free if res_valid=0, or if res_valid=1 and res_ready=1 in the issue cycle (accept and reload in the same cycle, no drop).
  - Free slot: res_data <= peak_q, res_pileup <= flag, res_valid <= 1, evt_count += 1 (saturating).
  - Full slot: the new result is discarded, drop_count += 1 (saturating), and the old result is retained.
- Handshake:
  - res_valid stays high until accepted.
  - res_data and res_pileup are stable while res_valid=1 and res_ready=0.
  - An accept with no new issue clears res_valid next cycle.
- enable=0 in any non-IDLE state: go to IDLE next cycle, filt_run=0 next cycle, and any in-flight pulse is abandoned.
  - A pending res_valid result is kept and can still be accepted in IDLE.
  - Re-enabling always passes through SETTLE again.
- Threshold changes outside IDLE have no effect.

Decomposition:
- Package (package_settings_v_5 style): trap_ctrl_state_t enum; result struct {amp[DATA_W], pileup}; default constants SETTLE_CYC, PEAK_DLY, MAX_WIDTH derived from k_v_5 and l_v_5.
- Sub-module: sat_counter (parameterised width, increment and clear inputs), used for evt_count and drop_count.
- FSM, counters and the result slot stay in trap_event_ctrl.

Test Plan:
- Bench parameters for all cases: SETTLE_CYC=32, PEAK_DLY=8, MAX_WIDTH=64, thr=100.
- Enable at cycle 0 with filt_data=500 throughout -> filt_run=1 at cycle 1; no trigger before cycle 33; trigger on the first WAIT_TRIG sample.
- Pulse above threshold for 20 cycles, with sample index 8 = 1234 -> one result: res_data=1234, res_pileup=0, evt_count=1, drop_count=0.
- Pulse above threshold for 5 cycles -> runt; no res_valid, evt_count unchanged.
- Pulse above threshold for 70 cycles -> result issued after the fall with res_pileup=1; exactly one result.
- res_ready=0 held during two pulses -> the first result is held stable and the second dropped (drop_count=1); set res_ready=1 in the second pulse's issue cycle -> no drop, the second result is loaded, evt_count=2.
- enable=0 during FLAT, then reset=0 with res_valid=1 -> next cycle: IDLE, filt_run=0; after reset: res_valid=0 and both counters=0.
